// File: rtl/dc_token_ring_wr_stage.sv
`default_nettype none
// ============================================================================
// Module      : dc_token_ring_wr_stage
// Description : Write-side half of a dual-clock token-ring FIFO. Accepts a
//               packed AXI channel word with valid/ready, stores it in a
//               register ring, publishes a one-hot write token to the remote
//               reader and returns the slot selected by the reader's raw
//               one-hot read pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module dc_token_ring_wr_stage #(
  parameter int DATA_WIDTH   = 32,
  parameter int BUFFER_DEPTH = 8,   // >= 3, usable capacity BUFFER_DEPTH-1
  parameter int SYNC_STAGES  = 2    // >= 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [DATA_WIDTH-1:0]   data_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  output logic [BUFFER_DEPTH-1:0] write_token_o,
  input  logic [BUFFER_DEPTH-1:0] read_pointer_i,
  output logic [DATA_WIDTH-1:0]   data_async_o
);

  localparam logic [BUFFER_DEPTH-1:0] TOKEN_RESET = BUFFER_DEPTH'(1);

  logic [BUFFER_DEPTH-1:0] token_q;
  logic [BUFFER_DEPTH-1:0] token_d;
  logic [BUFFER_DEPTH-1:0] token_rotl;
  logic [BUFFER_DEPTH-1:0] sync_q [SYNC_STAGES];
  logic [BUFFER_DEPTH-1:0] rp_sync;
  logic [DATA_WIDTH-1:0]   ring_q [BUFFER_DEPTH];
  logic                    full;
  logic                    write_en;

  assign rp_sync    = sync_q[SYNC_STAGES-1];
  assign token_rotl = {token_q[BUFFER_DEPTH-2:0], token_q[BUFFER_DEPTH-1]};

  // Full when the slot after the token is the reader's slot; a zero-hot
  // synchronised pointer (mid-move transient) is treated as full too.
  assign full     = ((token_rotl & rp_sync) != '0) || (rp_sync == '0);
  assign ready_o  = !full;
  assign write_en = valid_i && !full;

  // Token advances together with the data write, so the reader never sees
  // a token that is ahead of its data.
  assign token_d       = write_en ? token_rotl : token_q;
  assign write_token_o = token_q;

  // Write token register, driven straight to the reader domain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) token_q <= TOKEN_RESET;
    else         token_q <= token_d;
  end

  // Per-bit read pointer synchroniser chain.
  for (genvar s = 0; s < SYNC_STAGES; s++) begin : g_sync
    if (s == 0) begin : g_first
      // First stage samples the asynchronous pointer.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync_q[s] <= TOKEN_RESET;
        else         sync_q[s] <= read_pointer_i;
      end
    end else begin : g_next
      // Later stages shift the previous stage along.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync_q[s] <= TOKEN_RESET;
        else         sync_q[s] <= sync_q[s-1];
      end
    end
  end

  // Ring slots; a slot loads only when it holds the token and a write occurs.
  for (genvar i = 0; i < BUFFER_DEPTH; i++) begin : g_slot
    // Slot storage register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                      ring_q[i] <= '0;
      else if (write_en && token_q[i])  ring_q[i] <= data_i;
    end
  end

  // AND-OR mux over the raw pointer: zero-hot gives 0, multi-hot ORs slots.
  always_comb begin
    data_async_o = '0;
    for (int i = 0; i < BUFFER_DEPTH; i++) begin
      if (read_pointer_i[i]) data_async_o = data_async_o | ring_q[i];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dc_token_ring_wr_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_dc_token_ring_wr_stage
// Description : Self-checking bench for dc_token_ring_wr_stage with a
//               slot-index reference model and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dc_token_ring_wr_stage;

  localparam int DW = 32;
  localparam int D  = 8;
  localparam int S  = 2;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic [DW-1:0] data_i;
  logic          valid_i;
  logic          ready_o;
  logic [D-1:0]  write_token_o;
  logic [D-1:0]  read_pointer_i;
  logic [DW-1:0] data_async_o;

  int errors = 0;
  int checks = 0;

  // Reference model: slot contents, integer write index, pointer history.
  logic [DW-1:0] m_mem  [D];
  int            m_wr;
  logic [D-1:0]  m_hist [S];

  dc_token_ring_wr_stage #(
    .DATA_WIDTH   (DW),
    .BUFFER_DEPTH (D),
    .SYNC_STAGES  (S)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .data_i         (data_i),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .write_token_o  (write_token_o),
    .read_pointer_i (read_pointer_i),
    .data_async_o   (data_async_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  function automatic void m_reset();
    for (int i = 0; i < D; i++) m_mem[i] = '0;
    m_wr = 0;
    for (int s = 0; s < S; s++) m_hist[s] = D'(1);
  endfunction

  // Writer may proceed unless the next index is one the reader holds.
  function automatic logic m_ready();
    logic [D-1:0] rp;
    rp = m_hist[S-1];
    if (rp == '0) return 1'b0;
    return !rp[(m_wr + 1) % D];
  endfunction

  function automatic logic [D-1:0] m_token();
    logic [D-1:0] t;
    t = D'(1);
    return t << m_wr;
  endfunction

  function automatic logic [DW-1:0] m_mux(logic [D-1:0] rp);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < D; i++) if (rp[i]) r = r | m_mem[i];
    return r;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    check({tag, " ready"}, 32'(ready_o), 32'(m_ready()));
    check({tag, " token"}, 32'(write_token_o), 32'(m_token()));
    check({tag, " data_async"}, 32'(data_async_o), 32'(m_mux(read_pointer_i)));
  endtask

  // One clock cycle: drive inputs, advance the model at the edge, check.
  task automatic step(logic v, logic [DW-1:0] d, logic [D-1:0] rp, string tag);
    logic acc;
    valid_i        = v;
    data_i         = d;
    read_pointer_i = rp;
    @(posedge clk);
    acc = v && m_ready();
    if (acc) begin
      m_mem[m_wr] = d;
      m_wr        = (m_wr + 1) % D;
    end
    for (int s = S - 1; s > 0; s--) m_hist[s] = m_hist[s-1];
    m_hist[0] = rp;
    #1;
    check_all(tag);
  endtask

  // Asynchronous reset asserted between edges, released on a falling edge.
  task automatic do_reset(string tag);
    @(posedge clk);
    #3;
    rst_ni         = 1'b0;
    read_pointer_i = 8'h01;
    m_reset();
    #1;
    check({tag, " token"}, 32'(write_token_o), 32'h01);
    check({tag, " ready"}, 32'(ready_o), 32'h1);
    check({tag, " data_async"}, 32'(data_async_o), 32'h0);
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  initial begin
    logic [D-1:0]  cur_rp, rp;
    logic          v, pending;
    logic [DW-1:0] d;
    int            r;

    // Reset state
    rst_ni         = 1'b0;
    valid_i        = 1'b0;
    data_i         = '0;
    read_pointer_i = 8'h01;
    m_reset();
    #12;
    check("reset token", 32'(write_token_o), 32'h01);
    check("reset ready", 32'(ready_o), 32'h1);
    check("reset data_async", 32'(data_async_o), 32'h0);
    @(negedge clk);
    rst_ni = 1'b1;

    // Fill to capacity; the eighth word must be held off
    for (int k = 0; k < 8; k++) step(1'b1, DW'(32'hA0 + k), 8'h01, "fill");
    check("fill token", 32'(write_token_o), 32'h80);
    check("fill ready", 32'(ready_o), 32'h0);

    // Release: ready returns after two edges, then the held word wraps the ring
    step(1'b1, 32'hA7, 8'h02, "release1");
    check("release1 ready", 32'(ready_o), 32'h0);
    step(1'b1, 32'hA7, 8'h02, "release2");
    check("release2 ready", 32'(ready_o), 32'h1);
    step(1'b1, 32'hA7, 8'h02, "wrap");
    check("wrap token", 32'(write_token_o), 32'h01);
    check("wrap ready", 32'(ready_o), 32'h0);
    valid_i        = 1'b0;
    read_pointer_i = 8'h80;
    #1;
    check("slot7 data", 32'(data_async_o), 32'hA7);
    read_pointer_i = 8'h02;
    #1;

    // Read mux with no clock edge
    do_reset("reset2");
    step(1'b1, 32'h11, 8'h01, "mux_w0");
    step(1'b1, 32'h22, 8'h01, "mux_w1");
    valid_i        = 1'b0;
    read_pointer_i = 8'h02;
    #1;
    check("mux slot1", 32'(data_async_o), 32'h22);
    read_pointer_i = 8'h00;
    #1;
    check("mux zero-hot", 32'(data_async_o), 32'h0);

    // Zero-hot glitch: ready low for exactly one cycle, S edges later
    step(1'b0, '0, 8'h00, "glitch0");
    check("glitch0 ready", 32'(ready_o), 32'h1);
    step(1'b0, '0, 8'h01, "glitch1");
    check("glitch1 ready", 32'(ready_o), 32'h0);
    step(1'b0, '0, 8'h01, "glitch2");
    check("glitch2 ready", 32'(ready_o), 32'h1);

    // Two-hot pointer with the token at slot 7
    do_reset("reset3");
    for (int k = 0; k < 7; k++) step(1'b1, DW'($urandom), 8'h01, "fill2");
    step(1'b0, '0, 8'h03, "twohot1");
    step(1'b0, '0, 8'h03, "twohot2");
    check("twohot token", 32'(write_token_o), 32'h80);
    check("twohot ready", 32'(ready_o), 32'h0);
    step(1'b0, '0, 8'h02, "onehot1");
    step(1'b0, '0, 8'h02, "onehot2");
    check("onehot ready", 32'(ready_o), 32'h1);

    // Reset in the middle of a burst
    do_reset("reset4");
    for (int k = 0; k < 3; k++) step(1'b1, DW'($urandom), 8'h01, "burst");
    do_reset("midburst");
    step(1'b0, 32'h55, 8'h01, "post_reset_idle");
    check("post_reset token", 32'(write_token_o), 32'h01);
    step(1'b1, 32'h55, 8'h01, "post_reset_write");
    check("post_reset write token", 32'(write_token_o), 32'h02);

    // Randomized traffic with a loosely behaved reader pointer
    cur_rp  = 8'h01;
    pending = 1'b0;
    v       = 1'b0;
    d       = '0;
    for (int n = 0; n < 300; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 60)      rp = cur_rp;
      else if (r < 85) begin
        cur_rp = {cur_rp[D-2:0], cur_rp[D-1]};
        rp     = cur_rp;
      end
      else if (r < 92) rp = 8'h00;
      else             rp = D'($urandom);
      if (!pending) begin
        v = ($urandom_range(0, 2) != 0);
        d = DW'($urandom);
      end
      pending = v && !m_ready();
      step(v, d, rp, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dc_token_ring_wr_stage.md
Name: dc_token_ring_wr_stage

Overview:
- Write-side half of a dual-clock token-ring FIFO, one instance per AXI channel.
- Sits directly downstream of the AXI dual-clock slave slice's channel packing: it takes the packed AW/AR/W word with a valid/ready handshake in the local clock domain.
- Stores the word in a local register ring and publishes a one-hot write token to the remote reader.
- Returns the slot addressed by the reader's one-hot read pointer as data_async_o; the reader samples it in its own domain.

Parameters:
- DATA_WIDTH, 32: width of the packed channel word.
- BUFFER_DEPTH, 8: number of ring slots. Must be >= 3. Usable capacity is BUFFER_DEPTH-1.
- SYNC_STAGES, 2: flip-flop stages per bit when synchronising read_pointer_i. Must be >= 2.

Ports:
- clk_i  in  1  local write-domain clock.
- rst_ni  in  1  asynchronous active-low reset.
- data_i  in  DATA_WIDTH  packed channel word.
- valid_i  in  1  data_i valid.
- ready_o  out  1  slot available; the transfer occurs when valid_i && ready_o at a rising edge.
- write_token_o  out  BUFFER_DEPTH  one-hot index of the next slot to be written, sent to the reader domain.
- read_pointer_i  in  BUFFER_DEPTH  one-hot index of the reader's next slot. Asynchronous to clk_i.
- data_async_o  out  DATA_WIDTH  content of the slot selected by read_pointer_i, sent to the reader domain.

Behaviour:
- One clock (clk_i). Reset rst_ni is asynchronous and active-low. All flops clear on assertion; release is synchronous to clk_i.
- Reset values:
  - write_token_o = 'b1 (slot 0).
  - Synchronised read pointer rp_sync = 'b1 in every stage.
  - All ring slots = 0.
  - ready_o = 1.
  - data_async_o = 0 while read_pointer_i = 'b1.
- write_token_o is driven straight from its flops, with no logic after them; the reader synchronises it bit by bit.
- Synchroniser: each bit of read_pointer_i passes through SYNC_STAGES flops independently. rp_sync is the last stage.
- Full condition: full = ((rotl(write_token,1) & rp_sync) != 0) || (rp_sync == 0). ready_o = !full, combinational from flops only.
  - A zero-hot rp_sync (transient during a pointer move) counts as full.
  - A two-hot rp_sync still contains the old bit, so full stays conservative.
- Write, on the edge where valid_i && ready_o:
  - The slot selected by write_token is loaded with data_i.
  - write_token rotates left by 1 on the same edge: MSB wraps to bit 0.
  - Data and token update together, so the reader can never see a token ahead of its data.
- When valid_i is low or full: write_token and all slots hold.
- Valid/ready rules:
  - ready_o does not depend on valid_i.
  - Once asserted, valid_i and data_i must hold until accepted (upstream AXI rule). The block does not check this.
- data_async_o: combinational one-hot AND-OR mux of the slots over the raw read_pointer_i (not synchronised).
  - Zero-hot pointer gives 0.
  - Multi-hot pointer gives the OR of the selected slots; the reader never samples in that state.
- Latency:
  - Accepted data appears in write_token_o at the same edge.
  - A reader pointer advance raises ready_o after SYNC_STAGES rising edges of clk_i.
- Simultaneous write and pointer change: the write uses the current rp_sync. The newly freed slot becomes usable only after synchronisation.
- Reset mid-operation: stored words are discarded and the token returns to slot 0. The reader domain must be reset in the same window; the block does no cross-domain reset handshake.
- Area target: BUFFER_DEPTH*DATA_WIDTH data flops + BUFFER_DEPTH token flops + SYNC_STAGES*BUFFER_DEPTH sync flops.

Test Plan:
1. Reset with read_pointer_i=8'h01 -> write_token_o=8'h01, ready_o=1, data_async_o=0.
2. Fill: DEPTH=8, rp held at 8'h01, valid_i high, data 0xA0..0xA7 -> 0xA0..0xA6 accepted; ready_o low after the 7th edge; write_token_o=8'h80; 0xA7 held and not accepted.
3. Release with SYNC_STAGES=2: from test 2 set read_pointer_i=8'h02 ->
   - ready_o rises after the 2nd rising edge.
   - 0xA7 is written into slot 7 and write_token_o wraps to 8'h01.
   - ready_o drops again on that same edge.
4. Read mux: write 0x11 then 0x22, set read_pointer_i=8'h02 -> data_async_o=0x22 with no clock edge; set read_pointer_i=8'h00 -> data_async_o=0.
5. Pointer glitches: drive read_pointer_i 8'h00 for one cycle while not full ->
   - Zero-hot: ready_o low for exactly one cycle, starting SYNC_STAGES edges later.
   - Two-hot 8'h03 with token 8'h80: ready_o low.
6. Assert rst_ni mid-burst, asynchronously between edges -> write_token_o=8'h01 and ready_o=1 immediately; data_async_o=0 for read_pointer_i=8'h01; no write occurs on the edge after release unless valid_i is high.
